// File: rtl/vc_credit_pkg.sv
// Width helpers shared by the credit-based receive queue and the sender-side credit counter.
package vc_credit_pkg;

  // Pointer width for a buffer of n entries (at least one bit).
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width able to hold an occupancy/credit value from 0 to n inclusive.
  function automatic int count_width(input int n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

endpackage

// File: rtl/vc_credit_recv_queue_ctrl.sv
// Pointer, occupancy, credit-return and overflow control for the credit receive queue.
module vc_credit_recv_queue_ctrl
  import vc_credit_pkg::*;
#(
  parameter int NUM_ENTRIES = 4,
  localparam int PW = ptr_width(NUM_ENTRIES),
  localparam int CW = count_width(NUM_ENTRIES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enq_val,
  input  logic          deq_rdy,
  output logic          wr_en,
  output logic [PW-1:0] wr_ptr,
  output logic [PW-1:0] rd_ptr,
  output logic          deq_val,
  output logic [CW-1:0] count,
  output logic          credit_ret,
  output logic          overflow
);

  localparam logic [CW-1:0] FULL = CW'(NUM_ENTRIES);
  localparam logic [PW-1:0] LAST = PW'(NUM_ENTRIES - 1);

  logic [PW-1:0] wr_ptr_r, rd_ptr_r, wr_ptr_nxt_s, rd_ptr_nxt_s;
  logic [CW-1:0] count_r, count_nxt_s;
  logic          deq_val_r, credit_ret_r, overflow_r;
  logic          fire_s, full_s, enq_acc_s, ovf_s;

  // Accept/fire decisions and next-state values for pointers and occupancy.
  always_comb begin
    fire_s       = deq_val_r && deq_rdy;
    full_s       = (count_r == FULL);
    enq_acc_s    = 1'b0;
    ovf_s        = 1'b0;
    count_nxt_s  = count_r;
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    // A full buffer can still take a message when the head leaves in the same cycle.
    if (enq_val) begin
      if (!full_s || fire_s) begin
        enq_acc_s = 1'b1;
      end else begin
        ovf_s = 1'b1;
      end
    end else begin
      enq_acc_s = 1'b0;
    end
    case ({enq_acc_s, fire_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
    if (enq_acc_s) begin
      wr_ptr_nxt_s = (wr_ptr_r == LAST) ? PW'(0) : wr_ptr_r + PW'(1);
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end
    if (fire_s) begin
      rd_ptr_nxt_s = (rd_ptr_r == LAST) ? PW'(0) : rd_ptr_r + PW'(1);
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
  end

  // Control state; deq_val is registered alongside count so it never glitches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r     <= PW'(0);
      rd_ptr_r     <= PW'(0);
      count_r      <= CW'(0);
      deq_val_r    <= 1'b0;
      credit_ret_r <= 1'b0;
      overflow_r   <= 1'b0;
    end else begin
      wr_ptr_r     <= wr_ptr_nxt_s;
      rd_ptr_r     <= rd_ptr_nxt_s;
      count_r      <= count_nxt_s;
      deq_val_r    <= (count_nxt_s != CW'(0));
      credit_ret_r <= fire_s;
      overflow_r   <= overflow_r | ovf_s;
    end
  end

  assign wr_en      = enq_acc_s;
  assign wr_ptr     = wr_ptr_r;
  assign rd_ptr     = rd_ptr_r;
  assign deq_val    = deq_val_r;
  assign count      = count_r;
  assign credit_ret = credit_ret_r;
  assign overflow   = overflow_r;

endmodule

// File: rtl/vc_credit_recv_queue.sv
// Credit-flow-controlled receive buffer: circular storage plus read mux, control in a sub-module.
module vc_credit_recv_queue
  import vc_credit_pkg::*;
#(
  parameter int BIT_WIDTH   = 32,
  parameter int NUM_ENTRIES = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  enq_val,
  input  logic [BIT_WIDTH-1:0]                  enq_msg,
  output logic                                  deq_val,
  input  logic                                  deq_rdy,
  output logic [BIT_WIDTH-1:0]                  deq_msg,
  output logic                                  credit_ret,
  output logic [count_width(NUM_ENTRIES)-1:0]   count,
  output logic                                  overflow
);

  localparam int PW = ptr_width(NUM_ENTRIES);

  logic [BIT_WIDTH-1:0] mem_r [NUM_ENTRIES];
  logic                 wr_en_s;
  logic [PW-1:0]        wr_ptr_s, rd_ptr_s;

  vc_credit_recv_queue_ctrl #(
    .NUM_ENTRIES (NUM_ENTRIES)
  ) u_ctrl (
    .clk        (clk),
    .reset      (reset),
    .enq_val    (enq_val),
    .deq_rdy    (deq_rdy),
    .wr_en      (wr_en_s),
    .wr_ptr     (wr_ptr_s),
    .rd_ptr     (rd_ptr_s),
    .deq_val    (deq_val),
    .count      (count),
    .credit_ret (credit_ret),
    .overflow   (overflow)
  );

  // Storage is deliberately not reset; contents only matter while deq_val is high.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_s] <= enq_msg;
    end
  end

  assign deq_msg = mem_r[rd_ptr_s];

endmodule

// File: doc/vc_credit_recv_queue.md
VC_CREDIT_RECV_QUEUE -- requirements
Module: vc_credit_recv_queue

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 32, message payload width in bits.
REQ-002 SHALL have parameter NUM_ENTRIES, default 4, buffer depth; equals the sender's credit counter MAX_COUNT; legal range 1..64, non-power-of-two allowed.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port enq_val  input  1  sender presents a credited message this cycle; no ready back-pressure.
REQ-006 SHALL have port enq_msg  input  BIT_WIDTH  incoming message payload.
REQ-007 SHALL have port deq_val  output  1  buffer head is valid.
REQ-008 SHALL have port deq_rdy  input  1  consumer accepts head this cycle.
REQ-009 SHALL have port deq_msg  output  BIT_WIDTH  buffer head payload.
REQ-010 SHALL have port credit_ret  output  1  one-cycle pulse per freed entry, drives sender counter increment.
REQ-011 SHALL have port count  output  clog2(NUM_ENTRIES+1)  current occupancy.
REQ-012 SHALL have port overflow  output  1  sticky protocol-error flag.

Function
REQ-013 SHALL store messages in a circular buffer of NUM_ENTRIES entries with write and read pointers, each wrapping from NUM_ENTRIES-1 to 0.
REQ-014 SHALL write enq_msg at the write pointer on enq_val when count < NUM_ENTRIES, or when count == NUM_ENTRIES and a dequeue fires the same cycle.
REQ-015 SHALL drive deq_val = (count != 0) and deq_msg = entry at read pointer; no enqueue-to-dequeue bypass, so minimum enqueue-to-deq_val latency is 1 cycle.
REQ-016 SHALL treat deq_val && deq_rdy as a dequeue fire; advance read pointer on fire; deq_rdy with deq_val low has no effect.
REQ-017 SHALL update count +1 on accepted enqueue only, -1 on fire only, unchanged on both or neither.
REQ-018 SHALL assert credit_ret for exactly the one cycle after each fire, registered, with no merging: N fires yield N credit_ret pulses.
REQ-019 SHALL, on enq_val while count == NUM_ENTRIES with no fire, drop the message, leave state unchanged, and set overflow.
REQ-020 SHALL hold overflow high until reset.
REQ-021 SHALL keep deq_msg stable while deq_val is high and no fire occurs.

Reset
REQ-022 SHALL, on reset assertion (asynchronous), clear both pointers, set count = 0, and drive deq_val = 0, credit_ret = 0, overflow = 0 immediately.
REQ-023 SHALL discard buffered entries on reset mid-operation and emit no credit_ret for them; the sender's counter reset to MAX_COUNT restores balance.
REQ-024 SHALL not reset storage array contents; deq_msg is don't-care while deq_val is low.
REQ-025 SHALL hold all state at reset values while reset is high, ignoring enq_val and deq_rdy.

Structure
REQ-026 SHALL place shared pointer/count width helper constants in package vc_credit_pkg, also used by the sender-side counter wrapper.
REQ-027 SHALL split into one sub-module vc_credit_recv_queue_ctrl (pointers, count, credit_ret, overflow); the storage array and read mux stay in the top module.

Verification
REQ-028 SHALL cover fill to full: NUM_ENTRIES=4, deq_rdy=0, enqueue 0xA0..0xA3 on consecutive cycles -> count=4, deq_val=1, deq_msg=0xA0, credit_ret never high.
REQ-029 SHALL cover drain: from full, deq_rdy=1 for 4 cycles -> deq_msg sequence 0xA0,0xA1,0xA2,0xA3; credit_ret high on the 4 following cycles; count ends 0, deq_val=0.
REQ-030 SHALL cover simultaneous events: count=4, enq_val=1 with msg 0xB0 and fire in the same cycle -> count stays 4, overflow=0, 0xB0 emerges after 3 further fires.
REQ-031 SHALL cover overflow: count=4, deq_rdy=0, enq_val=1 with msg 0xFF -> count stays 4, overflow=1 next cycle and stays high; 0xFF never appears on deq_msg.
REQ-032 SHALL cover wrap and reset: NUM_ENTRIES=3, 7 enqueue/dequeue pairs -> in-order data across pointer wrap; async reset mid-stream with count=2 -> count=0, deq_val=0, credit_ret=0 immediately, no credit_ret afterwards.
REQ-033 SHALL cover closed-loop operation with a sender-side credit counter (MAX_COUNT=NUM_ENTRIES), random enq/deq for 1000 cycles -> overflow=0, sender credits + count + pending credit_ret == NUM_ENTRIES every cycle.
